// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold levels and bus types.
package pipe_ctrl_pkg;

    typedef logic [2:0]  Hold_Flag_Bus;
    typedef logic [31:0] InstAddrBus;

    localparam Hold_Flag_Bus Hold_None = 3'd0;
    localparam Hold_Flag_Bus Hold_Pc   = 3'd1;
    localparam Hold_Flag_Bus Hold_If   = 3'd2;
    localparam Hold_Flag_Bus Hold_Id   = 3'd3;

    function automatic Hold_Flag_Bus hold_max(input Hold_Flag_Bus a, input Hold_Flag_Bus b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// Bus-stall watchdog: counts consecutive bus-hold cycles and pulses once on reaching TIMEOUT.
module hold_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    output logic timeout_o
);

    localparam logic [7:0] Limit = 8'(TIMEOUT);
    localparam logic [7:0] Last  = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Saturates at Limit so the pulse cannot repeat until hold_i drops.
    always_comb begin
        cnt_d = '0;
        if (hold_i) begin
            cnt_d = (cnt_q != Limit) ? cnt_q + 8'd1 : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = !rst && hold_i && (cnt_q == Last);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hold merging, jump/interrupt redirects, drain FSM, bus watchdog.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         jump_flag_i,
    input  InstAddrBus   jump_addr_i,
    input  logic         hold_flag_ex_i,
    input  logic         hold_flag_rib_i,
    input  logic         int_req_i,
    input  InstAddrBus   int_addr_i,
    output logic         int_ack_o,
    output logic         jump_flag_o,
    output InstAddrBus   jump_addr_o,
    output Hold_Flag_Bus hold_flag_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  flush_cnt_o,
`endif
    output logic         bus_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_REDIRECT
    } state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   flush_q, flush_d;
    logic         jump_flag;
    InstAddrBus   jump_addr;
    logic         int_ack;
    Hold_Flag_Bus hold_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (int_req_i && !jump_flag_i && (flush_q == '0)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!int_req_i)                        state_d = S_IDLE;
                else if (!hold_flag_ex_i && !jump_flag_i) state_d = S_REDIRECT;
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        jump_flag = jump_flag_i;
        jump_addr = jump_flag_i ? jump_addr_i : '0;
        int_ack   = 1'b0;
        if (state_q == S_REDIRECT) begin
            jump_flag = 1'b1;
            jump_addr = int_addr_i;
            int_ack   = 1'b1;
        end

        hold_flag = Hold_None;
        if (hold_flag_rib_i)    hold_flag = hold_max(hold_flag, Hold_Pc);
        if (state_q == S_DRAIN) hold_flag = hold_max(hold_flag, Hold_If);
        if (jump_flag || (flush_q != '0) || hold_flag_ex_i) hold_flag = Hold_Id;
    end

    always_comb begin
        flush_d = '0;
        if (jump_flag)           flush_d = FlushLoad;
        else if (flush_q != '0)  flush_d = flush_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= '0;
        end else begin
            flush_q <= flush_d;
        end
    end

    assign jump_flag_o = rst ? 1'b0 : jump_flag;
    assign jump_addr_o = rst ? '0 : jump_addr;
    assign int_ack_o   = rst ? 1'b0 : int_ack;
    assign hold_flag_o = rst ? Hold_None : hold_flag;

    hold_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (hold_flag_rib_i),
        .timeout_o(bus_timeout_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + ((hold_flag_o != Hold_None) ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (jump_flag_o ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with FLUSH_CYCLES=3, TIMEOUT=4.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        logic         jf;
        logic [31:0]  ja;
        Hold_Flag_Bus hold;
        logic         ack;
        logic         to;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         jump_flag_i = 1'b0;
    InstAddrBus   jump_addr_i = '0;
    logic         hold_flag_ex_i = 1'b0;
    logic         hold_flag_rib_i = 1'b0;
    logic         int_req_i = 1'b0;
    InstAddrBus   int_addr_i = '0;
    logic         int_ack_o;
    logic         jump_flag_o;
    InstAddrBus   jump_addr_o;
    Hold_Flag_Bus hold_flag_o;
    logic         bus_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]  stall_cnt_o;
    logic [31:0]  flush_cnt_o;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FLUSH_CYCLES(3),
        .TIMEOUT     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .hold_flag_ex_i (hold_flag_ex_i),
        .hold_flag_rib_i(hold_flag_rib_i),
        .int_req_i      (int_req_i),
        .int_addr_i     (int_addr_i),
        .int_ack_o      (int_ack_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .hold_flag_o    (hold_flag_o),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
`endif
        .bus_timeout_o  (bus_timeout_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the edge and queue the outputs expected for it.
    task automatic cyc(input logic r, input logic jf, input logic [31:0] ja, input logic ex,
                       input logic rib, input logic irq, input logic [31:0] ia,
                       input logic e_jf, input logic [31:0] e_ja, input Hold_Flag_Bus e_hold,
                       input logic e_ack, input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; jump_flag_i = jf; jump_addr_i = ja; hold_flag_ex_i = ex;
        hold_flag_rib_i = rib; int_req_i = irq; int_addr_i = ia;
        e.jf = e_jf; e.ja = e_ja; e.hold = e_hold; e.ack = e_ack; e.to = e_to;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val("jump_flag", 32'(jump_flag_o), 32'(e.jf));
            check_val("jump_addr", jump_addr_o, e.ja);
            check_val("hold_flag", 32'(hold_flag_o), 32'(e.hold));
            check_val("int_ack", 32'(int_ack_o), 32'(e.ack));
            check_val("bus_timeout", 32'(bus_timeout_o), 32'(e.to));
        end
    end

    initial begin
        // reset with busy inputs: everything forced low
        cyc(1, 1, 32'h123, 1, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(1, 1, 32'h123, 1, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // jump flush: Hold_Id for exactly 3 cycles
        cyc(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'h100, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("flush_cnt", flush_cnt_o, 32'd1);
        check_val("stall_cnt", stall_cnt_o, 32'd3);
`endif

        // interrupt entry with ex busy for 2 cycles
        cyc(0, 0, 0, 1, 0, 1, 32'h80, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 32'h80, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_If, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h80, Hold_Id, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // jump and interrupt together: jump first, interrupt after flush drains
        cyc(0, 1, 32'h40, 0, 0, 1, 32'h80, 1, 32'h40, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_If, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h80, Hold_Id, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // ex jump during DRAIN passes through, then interrupt redirect
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(0, 1, 32'h200, 0, 0, 1, 32'h80, 1, 32'h200, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h80, Hold_Id, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_Id, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // watchdog: 10 cycles of bus hold, single pulse on the 4th
        for (int i = 1; i <= 10; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, Hold_Pc, 0, (i == 4));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, Hold_Pc, 0, (i == 4));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // request withdrawn during DRAIN: no ack
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h80, 0, 0, Hold_If, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        // reset during DRAIN aborts the sequence
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h80, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, Hold_None, 0, 0);

        @(posedge clk);
        @(posedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
